mic_capture_ctrl: RTL and testbench

Sequencing controller for the PDM microphone front end. It powers the microphone clock up and down, holds the PDM-to-PCM decimator in reset until the microphone has woken, and discards the decimator's start-up transient. It then buffers valid PCM samples in a small FIFO and presents them to the synthesizer input path over a valid/ready handshake. It sits between the decimator's `pcm_out`/`pcm_valid` and the audio processing chain, in the `pdm_clk` domain.

---
 rtl/mic_capture_pkg.sv | 23 ++
 rtl/mic_capture_ctrl_sample_fifo.sv | 48 ++++
 rtl/mic_capture_ctrl.sv | 140 ++++++++++++++
 tb/tb_mic_capture_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mic_capture_pkg.sv
// Shared types for the PDM microphone capture controller.
// The optional peak meter is enabled with `define MIC_CAPTURE_PEAK_EN.
package mic_capture_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAKE   = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } mic_state_e;

  typedef logic signed [15:0] pcm_sample_t;

  localparam logic [15:0] PCM_MAX = 16'd32767;

  // Absolute value that saturates -32768 to +32767 so it fits the signed range.
  function automatic logic [15:0] pcm_magnitude(input pcm_sample_t s);
    if (s == 16'sh8000) return PCM_MAX;
    else if (s < 0)     return -s;
    else                return s;
  endfunction

endpackage

// File: rtl/mic_capture_ctrl_sample_fifo.sv
// First-word-fall-through sample buffer; pointers carry one extra wrap bit
// so full and empty are distinguishable. Empty reads return zero.
module sample_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/mic_capture_ctrl.sv
// Power-up sequencing, settle discard and sample buffering for the PDM mic path.
// Define MIC_CAPTURE_PEAK_EN to build the peak magnitude meter.
module mic_capture_ctrl
  import mic_capture_pkg::*;
#(
  parameter int WAKE_CYCLES    = 65536,
  parameter int SETTLE_SAMPLES = 16,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic        pdm_clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        mute,
  output logic        mic_clk_en,
  output logic        dec_rstn,
  input  pcm_sample_t dec_pcm,
  input  logic        dec_valid,
  output pcm_sample_t smp_data,
  output logic        smp_valid,
  input  logic        smp_ready,
  output logic [1:0]  state,
  output logic        overflow,
  input  logic        ovf_clr,
  output logic [15:0] peak,
  input  logic        peak_clr
);

  localparam int WAKE_W      = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam int SETTLE_W    = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
  localparam int SETTLE_LAST = (SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0;

  mic_state_e          state_q, state_d;
  logic [WAKE_W-1:0]   wake_cnt_q, wake_cnt_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic                flush, push_req, pop, fifo_full, fifo_empty, ovf_q;
  pcm_sample_t         push_data;

  assign push_data = mute ? 16'sh0000 : dec_pcm;
  assign pop       = smp_valid && smp_ready;
  assign smp_valid = !fifo_empty;
  assign state     = state_q;
  assign overflow  = ovf_q;

  // Dropping enable from any active state returns to IDLE with counters cleared.
  always_comb begin
    state_d      = state_q;
    wake_cnt_d   = wake_cnt_q;
    settle_cnt_d = settle_cnt_q;
    flush        = 1'b0;
    push_req     = 1'b0;
    if (state_q != IDLE && !enable) begin
      state_d      = IDLE;
      wake_cnt_d   = '0;
      settle_cnt_d = '0;
    end
    case (state_q)
      IDLE: begin
        wake_cnt_d   = '0;
        settle_cnt_d = '0;
        if (enable) begin
          state_d = WAKE;
          flush   = 1'b1;
        end
      end
      WAKE: if (enable) begin
        if (wake_cnt_q == WAKE_W'(WAKE_CYCLES - 1)) begin
          state_d    = (SETTLE_SAMPLES == 0) ? RUN : SETTLE;
          wake_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + 1'b1;
        end
      end
      SETTLE: if (enable && dec_valid) begin
        if (settle_cnt_q == SETTLE_W'(SETTLE_LAST)) begin
          state_d      = RUN;
          settle_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      RUN: push_req = dec_valid;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pdm_clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      wake_cnt_q   <= '0;
      settle_cnt_q <= '0;
      mic_clk_en   <= 1'b0;
      dec_rstn     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wake_cnt_q   <= wake_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      mic_clk_en   <= (state_d != IDLE);
      dec_rstn     <= (state_d == SETTLE) || (state_d == RUN);
    end
  end

  // A simultaneous pop frees a slot, so only a push against a full, unpopped FIFO drops.
  always_ff @(posedge pdm_clk or negedge rstn) begin
    if (!rstn)                              ovf_q <= 1'b0;
    else if (push_req && fifo_full && !pop) ovf_q <= 1'b1;
    else if (ovf_clr)                       ovf_q <= 1'b0;
  end

  sample_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(16)) u_fifo (
    .clk_i   (pdm_clk),
    .rst_ni  (rstn),
    .flush_i (flush),
    .push_i  (push_req),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (smp_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef MIC_CAPTURE_PEAK_EN
  logic [15:0] peak_q, push_mag;

  assign push_mag = pcm_magnitude(push_data);
  assign peak     = peak_q;

  always_ff @(posedge pdm_clk or negedge rstn) begin
    if (!rstn) peak_q <= '0;
    else if (push_req) begin
      if (peak_clr || push_mag > peak_q) peak_q <= push_mag;
    end else if (peak_clr) peak_q <= '0;
  end
`else
  logic peak_clr_unused;

  assign peak_clr_unused = peak_clr;
  assign peak            = '0;
`endif

endmodule

// File: tb/tb_mic_capture_ctrl.sv
// Self-checking bench for mic_capture_ctrl: directed scenarios plus random traffic
// compared against a queue-based behavioural model of the capture session.
module tb_mic_capture_ctrl;

  localparam int WAKE   = 8;
  localparam int SETTLE = 2;
  localparam int DEPTH  = 8;

  logic        pdm_clk = 1'b0;
  logic        rstn;
  logic        enable, mute, dec_valid, smp_ready, ovf_clr, peak_clr;
  logic [15:0] dec_pcm;
  logic        mic_clk_en, dec_rstn, smp_valid, overflow;
  logic [15:0] smp_data, peak;
  logic [1:0]  state;

  int vectors = 0;
  int errors  = 0;

  // Behavioural model: session phase, plain counters and a sample queue.
  int          mPhase, mWake, mSettle;
  logic [15:0] mQ[$];
  logic        mOvf;
  logic [15:0] mPeak;

  mic_capture_ctrl #(.WAKE_CYCLES(WAKE), .SETTLE_SAMPLES(SETTLE), .FIFO_DEPTH(DEPTH)) dut (
    .pdm_clk(pdm_clk), .rstn(rstn), .enable(enable), .mute(mute),
    .mic_clk_en(mic_clk_en), .dec_rstn(dec_rstn), .dec_pcm(dec_pcm),
    .dec_valid(dec_valid), .smp_data(smp_data), .smp_valid(smp_valid),
    .smp_ready(smp_ready), .state(state), .overflow(overflow), .ovf_clr(ovf_clr),
    .peak(peak), .peak_clr(peak_clr)
  );

  always #5 pdm_clk = ~pdm_clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    mPhase = 0; mWake = 0; mSettle = 0; mQ.delete(); mOvf = 1'b0; mPeak = '0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic modelStep();
    bit          popNow, pushNow, ovfSet;
    logic [15:0] s;
    int          mag;
    popNow  = (mQ.size() > 0) && smp_ready;
    pushNow = (mPhase == 3) && dec_valid;
    s       = mute ? 16'h0000 : dec_pcm;
    ovfSet  = 0;
    if (mPhase == 0 && enable) mQ.delete();
    else begin
      if (popNow) void'(mQ.pop_front());
      if (pushNow) begin
        if (mQ.size() < DEPTH) mQ.push_back(s);
        else ovfSet = 1;
      end
    end
    if (ovfSet) mOvf = 1'b1;
    else if (ovf_clr) mOvf = 1'b0;
`ifdef MIC_CAPTURE_PEAK_EN
    mag = $signed(s);
    if (mag < 0) mag = -mag;
    if (mag > 32767) mag = 32767;
    if (pushNow) begin
      if (peak_clr || mag > int'(mPeak)) mPeak = 16'(mag);
    end else if (peak_clr) mPeak = '0;
`else
    mag = 0;
`endif
    if (mPhase != 0 && !enable) begin
      mPhase = 0; mWake = 0; mSettle = 0;
    end else begin
      case (mPhase)
        0: if (enable) begin mPhase = 1; mWake = 0; end
        1: begin
          mWake++;
          if (mWake == WAKE) begin mPhase = (SETTLE == 0) ? 3 : 2; mSettle = 0; end
        end
        2: if (dec_valid) begin
          mSettle++;
          if (mSettle == SETTLE) mPhase = 3;
        end
        default: ;
      endcase
    end
  endtask

  task automatic compareAll();
    checkOutput("state",    32'(state),      32'(mPhase));
    checkOutput("micClkEn", 32'(mic_clk_en), 32'(mPhase != 0));
    checkOutput("decRstn",  32'(dec_rstn),   32'(mPhase >= 2));
    checkOutput("smpValid", 32'(smp_valid),  32'(mQ.size() > 0));
    checkOutput("smpData",  32'(smp_data),   (mQ.size() > 0) ? 32'(mQ[0]) : 32'd0);
    checkOutput("overflow", 32'(overflow),   32'(mOvf));
    checkOutput("peak",     32'(peak),       32'(mPeak));
  endtask

  task automatic applyStimulus(input logic en, input logic mu, input logic [15:0] pcm,
                               input logic dv, input logic rdy, input logic oc, input logic pc);
    @(negedge pdm_clk);
    enable = en; mute = mu; dec_pcm = pcm; dec_valid = dv;
    smp_ready = rdy; ovf_clr = oc; peak_clr = pc;
    modelStep();
    @(posedge pdm_clk);
    #1;
    compareAll();
  endtask

  task automatic reachRun();
    for (int i = 0; i < 40 && mPhase != 3; i++)
      applyStimulus(1, 0, 16'(i), (mPhase == 2), 0, 0, 0);
    checkOutput("reachRun", 32'(state), 32'd3);
  endtask

  initial begin
    int n, cnt;
    rstn = 1'b0; enable = 0; mute = 0; dec_pcm = '0; dec_valid = 0;
    smp_ready = 0; ovf_clr = 0; peak_clr = 0;
    modelReset();
    #12;
    compareAll();
    @(negedge pdm_clk) rstn = 1'b1;

    // Wake timing and settle discard
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    n = 0;
    while (dec_rstn !== 1'b1 && n < 20) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      n++;
    end
    checkOutput("wakeEdges", 32'(n), 32'd8);
    applyStimulus(1, 0, 100, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 200, 1, 0, 0, 0);
    checkOutput("runAfterSettle", 32'(state), 32'd3);
    checkOutput("settleDiscard", 32'(smp_valid), 32'd0);
    applyStimulus(1, 0, 300, 1, 0, 0, 0);
    applyStimulus(1, 0, 400, 1, 0, 0, 0);
    checkOutput("head300", 32'(smp_data), 32'd300);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    checkOutput("head400", 32'(smp_data), 32'd400);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);

    // Overflow on the ninth push, then clear
    for (int i = 1; i <= 9; i++) applyStimulus(1, 0, 16'(i * 10), 1, 0, 0, 0);
    checkOutput("ovfSet", 32'(overflow), 32'd1);
    checkOutput("ovfHead", 32'(smp_data), 32'd10);
    applyStimulus(1, 0, 0, 0, 0, 1, 0);
    checkOutput("ovfClr", 32'(overflow), 32'd0);
    applyStimulus(1, 0, 777, 1, 1, 0, 0);
    checkOutput("fullPushPopOvf", 32'(overflow), 32'd0);
    checkOutput("fullPushPopHead", 32'(smp_data), 32'd20);
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 0, 1, 0, 0);
    checkOutput("drained", 32'(smp_valid), 32'd0);

    // Muted samples are zero and still delivered one per strobe
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 1, 1234, (i % 2 == 0), 1, 0, 0);
      if (smp_valid === 1'b1) begin
        cnt++;
        checkOutput("muteZero", 32'(smp_data), 32'd0);
      end
    end
    checkOutput("muteCount", 32'(cnt), 32'd5);

    // Disable keeps buffered samples; re-enable flushes them
    applyStimulus(1, 0, 11, 1, 0, 0, 0);
    applyStimulus(1, 0, 22, 1, 0, 0, 0);
    applyStimulus(1, 0, 33, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("offState", 32'(state), 32'd0);
    checkOutput("offMicClk", 32'(mic_clk_en), 32'd0);
    checkOutput("offHead", 32'(smp_data), 32'd11);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("offHead33", 32'(smp_data), 32'd33);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("reenFlush", 32'(smp_valid), 32'd0);
    checkOutput("reenWake", 32'(state), 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of WAKE
    #2 rstn = 1'b0;
    #1;
    modelReset();
    checkOutput("rstState", 32'(state), 32'd0);
    checkOutput("rstMicClk", 32'(mic_clk_en), 32'd0);
    checkOutput("rstDecRstn", 32'(dec_rstn), 32'd0);
    checkOutput("rstValid", 32'(smp_valid), 32'd0);
    enable = 0;
    @(negedge pdm_clk) rstn = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [15:0] pcm;
      pcm = ($urandom_range(0, 9) == 0) ? 16'h8000 : 16'($urandom);
      applyStimulus($urandom_range(0, 99) < 96, $urandom_range(0, 4) == 0, pcm,
                    $urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0);
    end

    // Peak meter
    reachRun();
    applyStimulus(1, 0, 16'h8000, 1, 1, 0, 0);
    applyStimulus(1, 0, 500, 1, 1, 0, 0);
`ifdef MIC_CAPTURE_PEAK_EN
    checkOutput("peakSat", 32'(peak), 32'd32767);
    applyStimulus(1, 0, 0, 0, 1, 0, 1);
    checkOutput("peakClr", 32'(peak), 32'd0);
`else
    checkOutput("peakTied", 32'(peak), 32'd0);
    applyStimulus(1, 0, 0, 0, 1, 0, 1);
    checkOutput("peakTiedClr", 32'(peak), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
